data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's load/store port. It is the target end of the request/response interface the pipeline's MEM stage drives.
- Accepts one word-addressed read or write request at a time and services it after a fixed, parameterised latency. It returns a response with read data and an error flag.
- Exposes `busy` so the CPU hazard logic can hold stages 1–4 while a request is outstanding.

Parameters:
- DEPTH, 256, number of 32-bit words of storage (≥2).
- ADDR_W, 32, width of the request address. Addresses are word indices, not byte addresses.
- LATENCY, 2, clock edges from request acceptance to resp_valid rising (≥1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read. Sampled on accept.
- req_addr  input  ADDR_W  word address. Sampled on accept.
- req_wdata  input  32  write data. Sampled on accept.
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU consumes the response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  address ≥ DEPTH.
- busy  output  1  request accepted and response not yet consumed.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latency counter=0.
  - Storage array is not reset; its contents are undefined until written.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid=1 at a rising edge. On that edge, latch we/addr/wdata, load cnt=LATENCY-1 and go to BUSY.
  - req_valid=0 stays in IDLE.
- BUSY:
  - req_ready=0. req_* inputs are ignored because the latched copy is used.
  - cnt≠0: decrement cnt and stay in BUSY.
  - cnt==0: perform the access on this edge and go to RESP with resp_valid=1.
- Access rules, executed on the edge entering RESP:
  - Latched addr ≥ DEPTH: resp_err=1, resp_rdata=0, storage unchanged.
  - Write: mem[addr]←wdata, resp_rdata=0, resp_err=0.
  - Read: resp_rdata←mem[addr], which reflects all previously committed writes; resp_err=0.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready=1 at an edge.
  - On that edge, resp_valid=0, resp_rdata=0, resp_err=0, and the state returns to IDLE.
  - A new request cannot be accepted in the same cycle as the response is consumed; req_ready rises the following cycle.
- Latency:
  - Accept at edge N → resp_valid=1 after edge N+LATENCY.
  - Minimum round trip with resp_ready held high: LATENCY+2 cycles per request.
- busy = (state≠IDLE), combinational from state.
- Address comparison uses the full ADDR_W bits; upper bits are never silently truncated.
- Reset asserted in BUSY: the pending write is discarded (never committed) and no response is produced.
- Reset asserted in RESP: the response is dropped, but a write already committed stays in storage.
- resp_ready=1 while not in RESP has no effect.

Test Plan:
- Write then read, LATENCY=2:
  - Write addr 5, data 0xDEADBEEF; accept at edge 0 → resp_valid high after edge 2 with rdata=0, err=0.
  - Read addr 5 → rdata=0xDEADBEEF exactly 2 edges after accept.
- Backpressure: hold resp_ready=0 for 4 cycles after resp_valid → resp_valid/rdata/err stable, req_ready=0, busy=1 throughout. Release → resp_valid drops next edge; req_ready=1 one cycle later.
- Out-of-range:
  - Write addr 256 (DEPTH=256), data 0x1234 → err=1, rdata=0.
  - Subsequent read of addr 0 returns its prior value, showing no aliasing.
  - Read addr 0xFFFFFFFF → err=1.
- Request during BUSY: change req_addr/req_we while BUSY → response reflects the originally latched request. Exactly one response per accepted request.
- Reset mid-operation: accept write addr 3 = 0xAA with LATENCY=3; drop rst after one edge → outputs return to reset values immediately. A later read of addr 3 does not return 0xAA (verify against a pre-loaded value of 0x55).
- LATENCY=1 back-to-back with resp_ready tied high → 10 alternating write/read requests complete with the correct data; each read response follows its accept by exactly 1 edge.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Load/store request/response bundle between MEM stage and memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Fixed-latency word-addressed data memory target for the CPU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input wire clk,
  input wire rst,
  data_mem_responder_if.slave bus
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [31:0]       mem [DEPTH];
  logic              in_range;
  logic              access;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;

  // Full-width compare so high address bits can never alias into storage.
  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  assign idx      = addr_q[IDX_W-1:0];
  assign access   = (state_q == ST_BUSY) && (cnt_q == '0);
  assign mem_we   = access && we_q && in_range;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = !in_range;
          resp_rdata_d = (in_range && !we_q) ? mem[idx] : 32'd0;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is deliberately unreset; a reset in BUSY leaves state_q idle so no write fires.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder at LATENCY 1, 2 and 3.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid  [1:3];
  logic        req_we     [1:3];
  logic [31:0] req_addr   [1:3];
  logic [31:0] req_wdata  [1:3];
  logic        resp_ready [1:3];
  logic        req_ready  [1:3];
  logic        resp_valid [1:3];
  logic [31:0] resp_rdata [1:3];
  logic        resp_err   [1:3];
  logic        busy       [1:3];

  // Instance index equals its LATENCY.
  for (genvar g = 1; g <= 3; g++) begin : g_dut
    data_mem_responder_if #(.ADDR_W(32)) bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_err[g]    = bus.resp_err;
    assign busy[g]        = bus.busy;

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(g)) u_dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.slave)
    );
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem   [1:3][0:DEPTH-1];
  bit          model_known [1:3][0:DEPTH-1];

  function automatic void model_apply(input int d, input bit we,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    if (we && addr < DEPTH) begin
      model_mem[d][addr]   = wdata;
      model_known[d][addr] = 1'b1;
    end
  endfunction

  // Drives one request, optionally sprays junk requests while the DUT is busy,
  // and returns edges from accept to resp_valid plus the response payload.
  task automatic send(input int d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit noise,
                      output int lat, output logic [31:0] rdata, output logic err);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk); #1;
    req_valid[d] = noise;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = $urandom % 16;
    req_wdata[d] = $urandom;
    lat = 0;
    while (resp_valid[d] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (noise) begin
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom % 16;
        req_wdata[d] = $urandom;
      end
    end
    req_valid[d] = 1'b0;
    rdata = resp_rdata[d];
    err   = resp_err[d];
  endtask

  task automatic consume(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int d = 1; d <= 3; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 ||
          resp_err[d] !== 1'b0 || busy[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state[%0d]: got rdy=%b vld=%b rdata=%h err=%b busy=%b expected 1 0 0 0 0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d], busy[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    send(2, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 32'd0 || er !== 1'b0) begin
      failures++;
      $display("FAIL write5: got lat=%0d rdata=%h err=%b expected lat=2 rdata=0 err=0", lat, rd, er);
    end
    consume(2);
    model_apply(2, 1'b1, 32'd5, 32'hDEADBEEF);
    send(2, 1'b0, 32'd5, 32'd0, 1'b0, lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL read5: got lat=%0d rdata=%h err=%b expected lat=2 rdata=deadbeef err=0", lat, rd, er);
    end
    consume(2);
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    send(2, 1'b0, 32'd5, 32'd0, 1'b0, lat, rd, er);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid[2] !== 1'b1 || resp_rdata[2] !== 32'hDEADBEEF || resp_err[2] !== 1'b0 ||
          req_ready[2] !== 1'b0 || busy[2] !== 1'b1) begin
        failures++;
        $display("FAIL hold[%0d]: got vld=%b rdata=%h err=%b rdy=%b busy=%b expected 1 deadbeef 0 0 1",
                 i, resp_valid[2], resp_rdata[2], resp_err[2], req_ready[2], busy[2]);
      end
    end
    resp_ready[2] = 1'b1;
    #1;
    checks++;
    if (req_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL rdy_during_consume: got %b expected 0", req_ready[2]);
    end
    @(posedge clk); #1;
    resp_ready[2] = 1'b0;
    checks++;
    if (resp_valid[2] !== 1'b0 || resp_rdata[2] !== 32'd0 || req_ready[2] !== 1'b1 || busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL release: got vld=%b rdata=%h rdy=%b busy=%b expected 0 0 1 0",
               resp_valid[2], resp_rdata[2], req_ready[2], busy[2]);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er; logic [31:0] v0;
    v0 = $urandom;
    send(2, 1'b1, 32'd0, v0, 1'b0, lat, rd, er);
    consume(2);
    model_apply(2, 1'b1, 32'd0, v0);
    send(2, 1'b1, 32'd256, 32'h1234, 1'b0, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
      failures++;
      $display("FAIL oor_write256: got err=%b rdata=%h lat=%0d expected err=1 rdata=0 lat=2", er, rd, lat);
    end
    consume(2);
    send(2, 1'b0, 32'd0, 32'd0, 1'b0, lat, rd, er);
    checks++;
    if (rd !== model_mem[2][0] || er !== 1'b0) begin
      failures++;
      $display("FAIL alias_read0: got rdata=%h err=%b expected rdata=%h err=0", rd, er, model_mem[2][0]);
    end
    consume(2);
    send(2, 1'b1, 32'h8000_0005, 32'h0BAD_0BAD, 1'b0, lat, rd, er);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL oor_highbit: got err=%b expected 1", er);
    end
    consume(2);
    send(2, 1'b0, 32'd5, 32'd0, 1'b0, lat, rd, er);
    checks++;
    if (rd !== model_mem[2][5]) begin
      failures++;
      $display("FAIL alias_read5: got %h expected %h", rd, model_mem[2][5]);
    end
    consume(2);
    send(2, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, lat, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL oor_read_max: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
    end
    consume(2);
  endtask

  task automatic test_busy_requests();
    int lat; logic [31:0] rd; logic er; logic [31:0] v; bit extra;
    v = $urandom;
    send(2, 1'b1, 32'd9, v, 1'b1, lat, rd, er);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      failures++;
      $display("FAIL busy_write: got lat=%0d err=%b rdata=%h expected 2 0 0", lat, er, rd);
    end
    consume(2);
    model_apply(2, 1'b1, 32'd9, v);
    send(2, 1'b0, 32'd9, 32'd0, 1'b1, lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== v || er !== 1'b0) begin
      failures++;
      $display("FAIL busy_read: got lat=%0d rdata=%h err=%b expected lat=2 rdata=%h err=0", lat, rd, er, v);
    end
    consume(2);
    extra = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid[2] !== 1'b0 || busy[2] !== 1'b0) extra = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL single_response: got extra activity=1 expected 0");
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic er;
    bit we; logic [31:0] addr, wdata, exp_rd; logic exp_er; int sel;
    for (int i = 0; i < 40; i++) begin
      we    = 1'($urandom);
      sel   = $urandom % 8;
      addr  = (sel < 6) ? ($urandom % 16) : (sel == 6) ? (256 + $urandom % 1000) : ($urandom | 32'h8000_0000);
      wdata = $urandom;
      exp_er = (addr >= DEPTH);
      exp_rd = (exp_er || we) ? 32'd0 : model_mem[2][addr[7:0]];
      send(2, we, addr, wdata, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 2 || er !== exp_er ||
          ((exp_er || we || model_known[2][addr[7:0]]) && rd !== exp_rd)) begin
        failures++;
        $display("FAIL rand[%0d] we=%b addr=%h: got lat=%0d rdata=%h err=%b expected lat=2 rdata=%h err=%b",
                 i, we, addr, lat, rd, er, exp_rd, exp_er);
      end
      consume(2);
      model_apply(2, we, addr, wdata);
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] rd; logic er; logic [31:0] v;
    send(3, 1'b1, 32'd3, 32'h55, 1'b0, lat, rd, er);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL lat3: got %0d expected 3", lat);
    end
    consume(3);
    model_apply(3, 1'b1, 32'd3, 32'h55);
    req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = 32'd3; req_wdata[3] = 32'hAA;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready[3] !== 1'b1 || resp_valid[3] !== 1'b0 || busy[3] !== 1'b0 ||
        resp_rdata[3] !== 32'd0 || resp_err[3] !== 1'b0) begin
      failures++;
      $display("FAIL busy_reset: got rdy=%b vld=%b busy=%b rdata=%h err=%b expected 1 0 0 0 0",
               req_ready[3], resp_valid[3], busy[3], resp_rdata[3], resp_err[3]);
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    send(3, 1'b0, 32'd3, 32'd0, 1'b0, lat, rd, er);
    checks++;
    if (rd !== model_mem[3][3] || er !== 1'b0) begin
      failures++;
      $display("FAIL discarded_write: got rdata=%h err=%b expected rdata=%h err=0", rd, er, model_mem[3][3]);
    end
    consume(3);
    // Reset while the response is pending: write already committed must survive.
    v = $urandom;
    send(3, 1'b1, 32'd7, v, 1'b0, lat, rd, er);
    model_apply(3, 1'b1, 32'd7, v);
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid[3] !== 1'b0 || busy[3] !== 1'b0) begin
      failures++;
      $display("FAIL resp_reset: got vld=%b busy=%b expected 0 0", resp_valid[3], busy[3]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3, 1'b0, 32'd7, 32'd0, 1'b0, lat, rd, er);
    checks++;
    if (rd !== model_mem[3][7]) begin
      failures++;
      $display("FAIL committed_write: got %h expected %h", rd, model_mem[3][7]);
    end
    consume(3);
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er; logic [31:0] addr, wdata, exp_rd; bit we;
    resp_ready[1] = 1'b1;
    addr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      we = (i % 2 == 0);
      if (we) addr = $urandom % DEPTH;
      wdata  = $urandom;
      exp_rd = we ? 32'd0 : model_mem[1][addr[7:0]];
      checks++;
      if (req_ready[1] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready[1]);
      end
      send(1, we, addr, wdata, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 1 || rd !== exp_rd || er !== 1'b0) begin
        failures++;
        $display("FAIL b2b[%0d] we=%b addr=%0d: got lat=%0d rdata=%h err=%b expected lat=1 rdata=%h err=0",
                 i, we, addr, lat, rd, er, exp_rd);
      end
      model_apply(1, we, addr, wdata);
      @(posedge clk); #1;
      checks++;
      if (resp_valid[1] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_drop[%0d]: got vld=%b expected 0", i, resp_valid[1]);
      end
    end
    resp_ready[1] = 1'b0;
  endtask

  initial begin
    for (int d = 1; d <= 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        model_mem[d][a]   = 32'd0;
        model_known[d][a] = 1'b0;
      end
    end
    test_reset();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_busy_requests();
    test_random();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
